// File: rtl/pu_riscv_ram_1r1w_reader.sv
// Burst read engine for the registered-output 1R1W RAM: issues one read per cycle
// and re-times the 1-cycle-latency data onto a valid/ready stream with last marking.
module pu_riscv_ram_1r1w_reader #(
   parameter int ABITS = 10,
   parameter int DBITS = 32,
   parameter int LBITS = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [ABITS-1:0] base_i,
   input  logic [LBITS-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [ABITS-1:0] ram_raddr_o,
   output logic             ram_re_o,
   input  logic [DBITS-1:0] ram_dout_i,
   output logic [DBITS-1:0] m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             m_last_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [LBITS-1:0] REM_ZERO = {LBITS{1'b0}};
   localparam logic [LBITS-1:0] REM_ONE  = {{(LBITS-1){1'b0}}, 1'b1};
   localparam logic [ABITS-1:0] ADDR_ONE = {{(ABITS-1){1'b0}}, 1'b1};

   // Three-slot ring pointer; index 3 is never produced.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      logic [1:0] n;
      if (p == 2'd2) n = 2'd0;
      else           n = p + 2'd1;
      return n;
   endfunction

   state_t           state_r, state_nxt_s;
   logic [ABITS-1:0] addr_r;
   logic [LBITS-1:0] rem_r;
   logic             inflight_r, inflight_last_r;
   logic [DBITS-1:0] fifo_data_r [3];
   logic             fifo_last_r [3];
   logic [1:0]       wr_ptr_r, rd_ptr_r, count_r;
   logic [2:0]       credit_s;
   logic             issue_s, push_s, pop_s;

   // Read issue depends only on registered state; credit covers buffered plus in-flight words.
   always_comb begin
      credit_s = {1'b0, count_r} + {2'b00, inflight_r};
      issue_s  = (state_r == ST_BURST) && (rem_r != REM_ZERO) && (credit_s < 3'd3);
      push_s   = inflight_r;
      pop_s    = (count_r != 2'd0) && m_ready_i;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               if (len_i != REM_ZERO) state_nxt_s = ST_BURST;
               else                   state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (issue_s && (rem_r == REM_ONE)) state_nxt_s = ST_DRAIN;
            else                               state_nxt_s = ST_BURST;
         end
         ST_DRAIN: begin
            if (!inflight_r && (count_r == 2'd0)) state_nxt_s = ST_DONE;
            else                                  state_nxt_s = ST_DRAIN;
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State, address/count, latency tracking and output buffer.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r         <= ST_IDLE;
         addr_r          <= {ABITS{1'b0}};
         rem_r           <= REM_ZERO;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         wr_ptr_r        <= 2'd0;
         rd_ptr_r        <= 2'd0;
         count_r         <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            fifo_data_r[i] <= {DBITS{1'b0}};
            fifo_last_r[i] <= 1'b0;
         end
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && start_i) begin
            addr_r <= base_i;
            rem_r  <= len_i;
         end else if (issue_s) begin
            addr_r <= addr_r + ADDR_ONE;
            rem_r  <= rem_r - REM_ONE;
         end
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && (rem_r == REM_ONE);
         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= ram_dout_i;
            fifo_last_r[wr_ptr_r] <= inflight_last_r;
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign busy_o      = (state_r != ST_IDLE);
   assign done_o      = (state_r == ST_DONE);
   assign ram_re_o    = issue_s;
   assign ram_raddr_o = addr_r;
   assign m_valid_o   = (count_r != 2'd0);
   assign m_data_o    = fifo_data_r[rd_ptr_r];
   assign m_last_o    = fifo_last_r[rd_ptr_r] && (count_r != 2'd0);

endmodule

// File: tb/tb_pu_riscv_ram_1r1w_reader.sv
// Directed bench for pu_riscv_ram_1r1w_reader with a registered-output RAM model.
module tb_pu_riscv_ram_1r1w_reader;
   localparam int AB = 10;
   localparam int DB = 32;
   localparam int LB = 8;

   logic          clk = 1'b0;
   logic          rst_ni, start_i, m_ready_i;
   logic [AB-1:0] base_i, ram_raddr_o;
   logic [LB-1:0] len_i;
   logic          busy_o, done_o, ram_re_o, m_valid_o, m_last_o;
   logic [DB-1:0] ram_dout_i, m_data_o;
   logic [DB-1:0] mem [0:(1<<AB)-1];

   always #5 clk = ~clk;

   pu_riscv_ram_1r1w_reader #(.ABITS(AB), .DBITS(DB), .LBITS(LB)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .ram_raddr_o(ram_raddr_o), .ram_re_o(ram_re_o),
      .ram_dout_i(ram_dout_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
      .m_ready_i(m_ready_i), .m_last_o(m_last_o)
   );

   always_ff @(posedge clk) begin
      if (ram_re_o) ram_dout_i <= mem[ram_raddr_o];
   end

   int tests_run = 0;
   int tests_failed = 0;

   logic [AB-1:0] iss_addr_q [$];
   int            iss_cyc_q [$];
   logic [DB-1:0] beat_data_q [$];
   logic          beat_last_q [$];
   int            beat_cyc_q [$];
   int done_cnt, done_cyc, busy_cyc, first_valid_cyc, stab_err, credit_err;
   int post_rst_beats, post_rst_re;
   logic busy_after_done, rst_zero;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic outs_zero();
      return ({busy_o, done_o, ram_raddr_o, ram_re_o, m_data_o, m_valid_o, m_last_o} == '0);
   endfunction

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: reset after 5 beats, 3: extra start in BURST
   task automatic run(input logic [AB-1:0] base, input logic [LB-1:0] len, input int mode, input int ncyc);
      int issued, accepted, rst_phase;
      logic prev_stall, prev_last;
      logic [DB-1:0] prev_data;
      iss_addr_q.delete(); iss_cyc_q.delete();
      beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
      done_cnt = 0; done_cyc = 0; busy_cyc = 0; first_valid_cyc = 0;
      stab_err = 0; credit_err = 0; post_rst_beats = 0; post_rst_re = 0;
      busy_after_done = 1'bx; rst_zero = 1'b0;
      issued = 0; accepted = 0; rst_phase = 0;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
      @(negedge clk);
      start_i = 1'b1; base_i = base; len_i = len; m_ready_i = 1'b1;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (mode == 3 && cyc == 2) begin
            start_i = 1'b1; base_i = 10'h200; len_i = 8'd3;
         end
         if (rst_phase == 1) begin
            rst_ni = 1'b1;
            rst_zero = outs_zero();
            rst_phase = 2;
         end
         m_ready_i = (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'b1;
         if (prev_stall && !(m_valid_o && m_data_o == prev_data && m_last_o == prev_last))
            stab_err++;
         if (busy_o) busy_cyc++;
         if (done_o) begin done_cnt++; done_cyc = cyc; end
         if (done_cyc != 0 && cyc == done_cyc + 1) busy_after_done = busy_o;
         if (m_valid_o && first_valid_cyc == 0) first_valid_cyc = cyc;
         if (mode == 2 && rst_phase == 0 && beat_data_q.size() == 5) begin
            rst_ni = 1'b0;
            rst_phase = 1;
            prev_stall = 1'b0;
         end else begin
            if (ram_re_o) begin
               if (rst_phase == 2) post_rst_re++;
               if (issued - accepted >= 3) credit_err++;
               issued++;
               iss_addr_q.push_back(ram_raddr_o);
               iss_cyc_q.push_back(cyc);
            end
            if (m_valid_o && m_ready_i) begin
               if (rst_phase == 2) post_rst_beats++;
               else begin
                  beat_data_q.push_back(m_data_o);
                  beat_last_q.push_back(m_last_o);
                  beat_cyc_q.push_back(cyc);
               end
               accepted++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
         end
      end
   endtask

   task automatic chk_stream(input string tag, input logic [AB-1:0] base, input int len);
      logic [AB-1:0] a;
      chk({tag, "_nissue"}, iss_addr_q.size(), len);
      chk({tag, "_nbeat"}, beat_data_q.size(), len);
      for (int i = 0; i < len; i++) begin
         a = base + AB'(i);
         if (i < iss_addr_q.size()) chk($sformatf("%s_addr%0d", tag, i), iss_addr_q[i], a);
         if (i < beat_data_q.size()) begin
            chk($sformatf("%s_data%0d", tag, i), beat_data_q[i], 32'h1000_0000 + {22'd0, a});
            chk($sformatf("%s_last%0d", tag, i), beat_last_q[i], (i == len - 1));
         end
      end
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_busy_after"}, busy_after_done, 1'b0);
      chk({tag, "_credit"}, credit_err, 0);
      chk({tag, "_stable"}, stab_err, 0);
   endtask

   initial begin
      for (int k = 0; k < (1 << AB); k++) mem[k] = 32'h1000_0000 + k;
      rst_ni = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; m_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs_zero(), 1'b1);
      rst_ni = 1'b1;

      run(10'h010, 8'd4, 0, 20);
      chk_stream("basic", 10'h010, 4);
      chk("basic_first_valid", first_valid_cyc, 3);
      if (iss_cyc_q.size() == 4) chk("basic_issue_span", iss_cyc_q[3] - iss_cyc_q[0], 3);
      if (beat_cyc_q.size() == 4) chk("basic_beat_span", beat_cyc_q[3] - beat_cyc_q[0], 3);

      run(10'h040, 8'd8, 1, 45);
      chk_stream("bp", 10'h040, 8);
      if (iss_cyc_q.size() == 8) chk("bp_stalled", (iss_cyc_q[7] - iss_cyc_q[0]) > 7, 1'b1);

      run(10'h3FE, 8'd4, 0, 20);
      chk_stream("wrap", 10'h3FE, 4);

      run(10'h123, 8'd0, 0, 6);
      chk("zero_nissue", iss_addr_q.size(), 0);
      chk("zero_first_valid", first_valid_cyc, 0);
      chk("zero_done", done_cnt, 1);
      chk("zero_done_cyc", done_cyc, 1);
      chk("zero_busy_cyc", busy_cyc, 1);

      run(10'h080, 8'd16, 2, 30);
      chk("rst_nbeat", beat_data_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < beat_data_q.size())
            chk($sformatf("rst_data%0d", i), beat_data_q[i], 32'h1000_0080 + i);
      chk("rst_outs_zero", rst_zero, 1'b1);
      chk("rst_post_beats", post_rst_beats, 0);
      chk("rst_post_re", post_rst_re, 0);
      chk("rst_done", done_cnt, 0);

      run(10'h100, 8'd8, 3, 30);
      chk_stream("ign", 10'h100, 8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/pu_riscv_ram_1r1w_reader.md
Name: pu_riscv_ram_1r1w_reader

Overview:
Burst read engine that drives the read port of the team's registered-output 1R1W RAM.
- Accepts a command (base address, word count) and issues one RAM read per cycle.
- Absorbs the RAM's fixed 1-cycle read latency.
- Presents the words on a valid/ready stream with last-word marking and full backpressure.
- Sits between the RAM and consumers such as instruction prefetch, DMA or debug dump logic.

Parameters:
ABITS, 10, RAM address width; addresses wrap modulo 2**ABITS.
DBITS, 32, RAM data width and stream data width.
LBITS, 8, width of the burst length field.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  command strobe, sampled only in IDLE
base_i  in  ABITS  first word address of the burst
len_i  in  LBITS  number of words to read, 0 allowed
busy_o  out  1  high from command acceptance until done_o
done_o  out  1  single-cycle pulse when the burst is complete
ram_raddr_o  out  ABITS  RAM read address, registered
ram_re_o  out  1  high in cycles where ram_raddr_o is a real read
ram_dout_i  in  DBITS  RAM read data, valid the cycle after the address
m_data_o  out  DBITS  stream data
m_valid_o  out  1  stream valid
m_ready_i  in  1  stream ready from consumer
m_last_o  out  1  marks the final word of the burst

Behaviour:
- Reset: the clock is clk_i; reset is synchronous and active-low on rst_ni.
  - All outputs go to 0 at reset: busy_o, done_o, ram_raddr_o, ram_re_o, m_data_o, m_valid_o, m_last_o.
  - FSM returns to IDLE; remaining count, in-flight flag and output buffer are cleared.
  - Reset mid-burst discards all buffered and in-flight data; no stream transfer follows.
- State machine:
  - IDLE: start_i=1 latches base_i into the address register and len_i into the remaining counter.
    - If len_i!=0, go to BURST and set busy_o=1.
    - If len_i==0, go to DONE and set busy_o=1 for that one cycle; no RAM read, no stream beat.
  - BURST: issue a read when remaining>0 and (buf_count + inflight) < 3.
    - On issue: ram_re_o=1, and ram_raddr_o shows the current address.
    - At the edge: address increments by 1 (wraps at 2**ABITS), remaining decrements, inflight is set.
    - When the final read is issued (remaining 1->0), go to DRAIN.
  - DRAIN: wait until inflight==0 and buf_count==0 with the last beat accepted, then go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o drops to 0 at the following edge, return to IDLE.
  - start_i outside IDLE is ignored.
- ram_re_o is combinational from registered state only; it must not depend on m_ready_i.
- ram_raddr_o holds its value when not issuing.
- Latency:
  - inflight is a register equal to ram_re_o delayed one cycle.
  - When inflight=1, ram_dout_i is written into the buffer at that edge.
  - First m_valid_o rises two edges after the edge that accepts start_i.
- Output buffer:
  - 3-entry FIFO; credit counts buffered plus in-flight words, so no overflow is possible.
  - Head drives m_data_o and m_last_o.
- Throughput: 1 word/cycle sustained while m_ready_i stays high.
- Stream rules:
  - A beat transfers when m_valid_o && m_ready_i.
  - m_data_o and m_last_o stay stable while m_valid_o && !m_ready_i.
  - m_valid_o never drops without a transfer.
  - m_last_o=1 only on word number len, counting from 1.
- Simultaneous push and pop in the same cycle: occupancy is unchanged and ordering is preserved.

Test Plan:
- Basic burst:
  - Stimulus: RAM preloaded mem[k]=0x1000_0000+k; start base=0x010, len=4; m_ready_i=1.
  - Required: addresses 0x010..0x013 on consecutive cycles; data 0x1000_0010..0x1000_0013 on 4 consecutive beats; m_last_o on the 4th beat; done_o pulses once; busy_o low afterwards.
- Backpressure:
  - Stimulus: len=8; m_ready_i toggles 1,0,0,1,...
  - Required: no word lost or duplicated; ram_re_o stalls when buf_count+inflight=3; data is stable during stalls.
- Wrap:
  - Stimulus: ABITS=10, base=0x3FE, len=4.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001; data is mem at those addresses in order.
- Zero length:
  - Stimulus: start with len=0.
  - Required: ram_re_o never asserted; m_valid_o stays 0; done_o pulses 1 cycle after start; busy_o high for that 1 cycle only.
- Reset mid-burst and start ignored:
  - Stimulus: len=16; pull rst_ni low for 1 cycle after 5 beats; assert start_i during BURST in a separate run.
  - Required: after reset all outputs are 0 and no further beats appear; the extra start_i has no effect on address or count.
